usb_ep_arbiter: RTL

- Round-robin arbiter sharing one USB IN-endpoint data interface (put/data/done) between N_REQ local requesters, for example the serial bridge and a descriptor/status responder.
- A grant is held for a whole packet fill and is released only when the owner drops its request.
- Sits between the requesters and the endpoint's IN data port; muxes the owner's signals onto the endpoint and blocks everyone else.

---
 rtl/usb_ep_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/usb_ep_arbiter.sv
// usb_ep_arbiter: round-robin owner arbitration of one USB IN-endpoint data port.
// Ports: i_clk/i_rst (async active-low); i_req/o_grant per-requester handshake;
// i_dataPut/i_data/i_dataDone requester data; i_epDataFree endpoint space;
// o_dataFree gated space; o_epReq/o_epDataPut/o_epData/o_epDataDone muxed
// endpoint side; o_grantIdx current owner; o_err sticky protocol violation.
module usb_ep_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  output logic [N_REQ-1:0]   o_grant,
  input  logic [N_REQ-1:0]   i_dataPut,
  input  logic [8*N_REQ-1:0] i_data,
  input  logic [N_REQ-1:0]   i_dataDone,
  input  logic               i_epDataFree,
  output logic [N_REQ-1:0]   o_dataFree,
  output logic               o_epReq,
  output logic               o_epDataPut,
  output logic [7:0]         o_epData,
  output logic               o_epDataDone,
  output logic [IDX_W-1:0]   o_grantIdx,
  output logic               o_err
);
  typedef enum logic [1:0] {IDLE, OWNED, GAP} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] owner, owner_n, rr, rr_n, win;
  logic [N_REQ-1:0] grant_n;
  logic found, err_n;
  int j;
  // Scan from the highest offset down so the lowest offset from rr wins.
  always_comb begin
    win = '0;
    found = 1'b0;
    j = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = (int'(rr) + i) % N_REQ;
      if (i_req[j]) begin
        win = IDX_W'(j);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_n = rr;
    grant_n = o_grant;
    unique case (state)
      IDLE: if (found) begin
        state_n = OWNED;
        owner_n = win;
        grant_n = N_REQ'(1) << win;
      end
      OWNED: if (!i_req[owner]) begin
        state_n = GAP;
        owner_n = '0;
        grant_n = '0;
        rr_n = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  assign err_n = o_err | (|((i_dataPut | i_dataDone) & ~o_grant))
               | ((|(i_dataPut & o_grant)) & ~i_epDataFree);
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      owner <= '0;
      rr <= '0;
      o_grant <= '0;
      o_err <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      rr <= rr_n;
      o_grant <= grant_n;
      o_err <= err_n;
    end
  end
  assign o_epReq = |o_grant;
  assign o_dataFree = o_grant & {N_REQ{i_epDataFree}};
  assign o_epDataPut = o_epReq & i_dataPut[owner] & i_epDataFree;
  assign o_epData = o_epReq ? i_data[{owner, 3'b000} +: 8] : 8'h00;
  assign o_epDataDone = o_epReq & i_dataDone[owner];
  assign o_grantIdx = owner;
endmodule
